// File: rtl/memory_adaptor.sv
// Shares the single byte-wide memory port between instruction fetch and the LSU.
// Each granted task is serialised into pipelined byte accesses and finishes with a one-cycle done pulse.
module memory_adaptor (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic        request_ins_from_memory_adaptor,
    input  logic [31:0] insaddr_to_be_fetched_from_memory_adaptor,
    output logic [31:0] ins_fetched_from_memory_adaptor,
    output logic        insfetch_task_done,
    input  logic        lsu_request,
    input  logic        lsu_is_write,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic [31:0] lsu_write_data,
    output logic [31:0] lsu_read_data,
    output logic        lsu_task_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

    state_t      state_q, state_d;
    logic        lastIf_q, lastIf_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  count_q, count_d;
    logic [2:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] insData_q, insData_d;
    logic [31:0] lsuData_q, lsuData_d;
    logic        insDone_q, insDone_d;
    logic        lsuDone_q, lsuDone_d;

    logic        ifReq, lsReq, grantIf, grantLs;
    logic        flushed, reading, readAccess, capture, readDone;
    logic        ioStall, writeAccess, writeDone;
    logic [2:0]  lsuBytes;
    logic [1:0]  pendIdx;
    logic [31:0] curAddr, merged;

    // A requester whose done is pulsing this cycle is still holding its old request; ignore it.
    always_comb begin
        ifReq    = request_ins_from_memory_adaptor && !flush_pipline && !insDone_q;
        lsReq    = lsu_request && !lsuDone_q;
        grantIf  = (state_q == IDLE) && rdy_in && ifReq && (!lsReq || !lastIf_q);
        grantLs  = (state_q == IDLE) && rdy_in && lsReq && !grantIf;
        case (lsu_size)
            2'd0:    lsuBytes = 3'd1;
            2'd1:    lsuBytes = 3'd2;
            default: lsuBytes = 3'd4;
        endcase
        curAddr     = addr_q + {29'd0, idx_q};
        flushed     = (state_q == IF_READ) && flush_pipline;
        reading     = rdy_in && !flushed && ((state_q == IF_READ) || (state_q == LS_READ));
        readAccess  = reading && (idx_q < count_q);
        capture     = reading && pend_q;
        readDone    = capture && (idx_q == count_q);
        ioStall     = (curAddr[17:16] == 2'b11) && io_buffer_full;
        writeAccess = rdy_in && (state_q == LS_WRITE) && !ioStall;
        writeDone   = writeAccess && (idx_q == count_q - 3'd1);
        pendIdx     = idx_q[1:0] - 2'd1;
        merged      = buf_q;
        merged[{pendIdx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            lastIf_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            buf_q     <= '0;
            insData_q <= '0;
            lsuData_q <= '0;
            insDone_q <= 1'b0;
            lsuDone_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lastIf_q  <= lastIf_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            buf_q     <= buf_d;
            insData_q <= insData_d;
            lsuData_q <= lsuData_d;
            insDone_q <= insDone_d;
            lsuDone_q <= lsuDone_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lastIf_d  = lastIf_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        count_d   = count_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        buf_d     = buf_q;
        insData_d = insData_q;
        lsuData_d = lsuData_q;
        insDone_d = rdy_in ? 1'b0 : insDone_q;
        lsuDone_d = rdy_in ? 1'b0 : lsuDone_q;
        unique case (state_q)
            IDLE: begin
                if (grantIf || grantLs) begin
                    state_d  = grantIf ? IF_READ : (lsu_is_write ? LS_WRITE : LS_READ);
                    lastIf_d = grantIf;
                    addr_d   = grantIf ? insaddr_to_be_fetched_from_memory_adaptor : lsu_addr;
                    count_d  = grantIf ? 3'd4 : lsuBytes;
                    wdata_d  = lsu_write_data;
                    idx_d    = '0;
                    pend_d   = 1'b0;
                    buf_d    = '0;
                end
            end
            IF_READ, LS_READ: begin
                if (flushed) begin
                    state_d = IDLE;
                end else if (!rdy_in) begin
                    // Data due during a pause is lost, so that byte is addressed again on resume.
                    if (pend_q) begin
                        idx_d  = idx_q - 3'd1;
                        pend_d = 1'b0;
                    end
                end else begin
                    if (capture)    buf_d = merged;
                    if (readAccess) idx_d = idx_q + 3'd1;
                    pend_d = readAccess;
                    if (readDone) begin
                        state_d = IDLE;
                        if (state_q == IF_READ) begin
                            insData_d = merged;
                            insDone_d = 1'b1;
                        end else begin
                            lsuData_d = merged;
                            lsuDone_d = 1'b1;
                        end
                    end
                end
            end
            LS_WRITE: begin
                if (writeAccess) begin
                    idx_d = idx_q + 3'd1;
                    if (writeDone) begin
                        state_d   = IDLE;
                        lsuDone_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        if (readAccess) mem_a = curAddr;
        if (writeAccess) begin
            mem_a    = curAddr;
            mem_wr   = 1'b1;
            mem_dout = wdata_q[{idx_q[1:0], 3'b000} +: 8];
        end
        insfetch_task_done              = insDone_q && rdy_in;
        lsu_task_done                   = lsuDone_q && rdy_in;
        ins_fetched_from_memory_adaptor = insData_q;
        lsu_read_data                   = lsuData_q;
    end

endmodule

// File: doc/memory_adaptor.md
# memory_adaptor

Arbiter and sequencer for the CPU's single byte-wide RAM/IO port. It shares the port between the instruction cache fetch path (32-bit reads) and the load/store path (1/2/4-byte reads and writes), and serialises each request into pipelined byte accesses. It returns one completed word or byte group per task with a single-cycle done pulse. It sits between the issue manager's cache and the LSU on one side and the top-level `mem_*` pins on the other.

## Interface
- No parameters. IO space is fixed as `addr[17:16] == 2'b11`.
- `clk_in` in 1: system clock; one clock domain.
- `rst_in` in 1: reset; synchronous, active-high.
- `rdy_in` in 1: pause when low.
- `flush_pipline` in 1: misprediction flush.
- `request_ins_from_memory_adaptor` in 1: ifetch request, level.
- `insaddr_to_be_fetched_from_memory_adaptor` in 32: ifetch byte address; may be halfword-aligned.
- `ins_fetched_from_memory_adaptor` out 32: fetched word, little-endian.
- `insfetch_task_done` out 1: ifetch done; high exactly 1 cycle per task.
- `lsu_request` in 1: LSU request, level.
- `lsu_is_write` in 1: 1 = store.
- `lsu_addr` in 32: LSU byte address.
- `lsu_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = word.
- `lsu_write_data` in 32: store data; the low N bytes are used.
- `lsu_read_data` out 32: load data, zero-extended; sign extension is done elsewhere.
- `lsu_task_done` out 1: LSU done; high exactly 1 cycle per task.
- `mem_din` in 8: RAM read byte; valid the cycle after its address is driven.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: UART buffer full.

## Operation
- **States:** IDLE, IF_READ, LS_READ, LS_WRITE.
- **Acceptance:** a task is accepted only in IDLE with `rdy_in` high. The task's address, size and data are latched at acceptance. Requesters must hold request and operands stable until done.
- **Arbitration:** round-robin on the last grant. If both request, grant the one not granted last. A lone requester is granted immediately. After reset the last grant = LSU, so ifetch wins the first tie.
- **Byte counts:** N = 4 for ifetch. For LSU, N = 1/2/4 per `lsu_size`. Byte i uses address `addr + i`, mod 2^32 (wraps past 0xFFFFFFFF).
- **Reads:** byte i is addressed in cycle i+1 after acceptance, with `mem_wr` = 0. `mem_din` in cycle i+2 is captured into bits `[8i+7:8i]`.
- **Writes:** byte i is driven in cycle i+1 after acceptance: `mem_a = addr + i`, `mem_dout = data[8i+7:8i]`, `mem_wr` = 1.
- **IO backpressure:** if a write targets IO space and `io_buffer_full` is high, drive `mem_wr` = 0 and `mem_a` = 0 that cycle and do not advance i.
- **Completion:** the task returns to IDLE on completion.
- **Idle outputs:** in IDLE, and on every non-access cycle, drive `mem_a` = 0 and `mem_wr` = 0. No speculative address may ever hit IO space.
- **Flush, ifetch:** `flush_pipline` aborts an in-flight ifetch. The next cycle is IDLE, no `insfetch_task_done` is produced, and already-captured bytes are discarded. An ifetch request in the flush cycle is not accepted.
- **Flush, LSU:** LSU tasks are never aborted by flush; they run to completion and pulse done.
- **Pause:** while `rdy_in` is low, all state holds, `mem_wr` = 0, `mem_a` = 0 and the done outputs are held low. On resume, the byte whose data was due during the pause is re-addressed before the sequence continues, costing 1 bubble cycle.
- **Data hold:** `ins_fetched_from_memory_adaptor` and `lsu_read_data` hold their last value until the next completion.

## Timing
- **Reset values:** all outputs 0; state IDLE; last-grant = LSU.
- **Read latency:** done is high in cycle N+2 after acceptance. An ifetch word read completes in cycle 6. Done and data are registered.
- **Write latency:** done is high in cycle N+1, plus any `io_buffer_full` stall cycles.
- **Back-to-back tasks:** a new task can be accepted in the done cycle, since the state is already IDLE. There is no dead cycle between tasks beyond this.
- **Ordering:** at most one task is in flight. Done for requester X never overlaps done for requester Y.

## Test plan
- **Ifetch word read:** RAM[0x100..0x103] = 0x13,0x05,0x00,0x00; ifetch 0x100 -> `mem_a` = 0x100..0x103 in cycles 1–4; `insfetch_task_done` in cycle 6 with data 0x00000513.
- **Simultaneous requests:** ifetch and LSU byte read of 0x200 (=0xAB) asserted together after reset -> ifetch served first; LSU accepted in ifetch's done cycle; `lsu_read_data` = 0x000000AB.
- **Halfword store:** store 0x1234BEEF, size 1, to 0x3FF -> `mem_a` 0x3FF/0x400 with `mem_dout` 0xEF/0xBE, `mem_wr` = 1; done in cycle 3.
- **IO write stall:** byte store 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles -> `mem_wr` stays 0 for 3 cycles, then one write; done 1 cycle later; `mem_a` = 0 while stalled.
- **Flush mid-fetch:** flush in cycle 3 of an ifetch -> no `insfetch_task_done`; IDLE in cycle 4 with `mem_a` = 0; a new ifetch at the flushed PC then completes normally.
- **Pause and reset:** `rdy_in` low for 2 cycles mid LSU word read -> correct word, done delayed by 3 cycles. Separately, `rst_in` mid-write -> all outputs 0 the next cycle and no done pulse.
